// File: rtl/access_req_pkg.sv
// Shared state encoding and result codes for the access requester slice.
package access_req_pkg;

   typedef enum logic [2:0] {
      IDLE,
      ISSUE,
      WAIT,
      LOCKOUT,
      DONE
   } state_t;

   localparam logic [1:0] RSP_GRANTED = 2'b00;
   localparam logic [1:0] RSP_DENIED  = 2'b01;
   localparam logic [1:0] RSP_LOCKED  = 2'b10;

endpackage

// File: rtl/access_req_fifo.sv
// Synchronous command FIFO; the head entry stays visible until popped so retries reuse it.
module access_req_fifo
   import access_req_pkg::*;
#(
   parameter int ID_W  = 32,
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic [ID_W-1:0]          push_data,
   input  logic                     pop,
   output logic [ID_W-1:0]          head,
   output logic                     full,
   output logic                     empty,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PTR_W = $clog2(DEPTH);

   logic [ID_W-1:0]  mem_q [DEPTH];
   logic [ID_W-1:0]  mem_d [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]   count_q, count_d;
   logic             do_push, do_pop;

   assign full    = (count_q == (PTR_W+1)'(DEPTH));
   assign empty   = (count_q == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem_q[rd_ptr_q];
   assign count   = count_q;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_push) begin
         mem_d[wr_ptr_q] = push_data;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (do_pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + (PTR_W+1)'(do_push) - (PTR_W+1)'(do_pop);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/access_requester.sv
// Initiator side of the ID access check: buffers commands, issues attempts, retries, reports.
// Optional result counters are enabled by defining ACCESS_REQ_STATS_EN.
module access_requester
   import access_req_pkg::*;
#(
   parameter int ID_W           = 32,
   parameter int FIFO_DEPTH     = 4,
   parameter int RESP_LAT       = 1,
   parameter int MAX_TRIES      = 3,
   parameter int LOCKOUT_CYCLES = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic [ID_W-1:0]  cmd_id,
   output logic             rsp_valid,
   input  logic             rsp_ready,
   output logic [1:0]       rsp_code,
   output logic [2:0]       rsp_tries,
   output logic [ID_W-1:0]  id_dynamic,
   output logic             req_valid,
   input  logic             access_granted,
   input  logic             access_denied,
   input  logic             irq_flag,
   output logic             lockout
`ifdef ACCESS_REQ_STATS_EN
   ,
   output logic [15:0]      grant_cnt,
   output logic [15:0]      deny_cnt,
   output logic [7:0]       lock_cnt
`endif
);

   localparam int CNT_MAX = (RESP_LAT > LOCKOUT_CYCLES) ? RESP_LAT : LOCKOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam int FCNT_W  = $clog2(FIFO_DEPTH) + 1;

   state_t           state_q, state_d;
   logic [2:0]       tries_q, tries_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [ID_W-1:0]  id_dynamic_q, id_dynamic_d;
   logic [1:0]       rsp_code_q, rsp_code_d;

   logic              fifo_push, fifo_pop, fifo_full, fifo_empty;
   logic [ID_W-1:0]   fifo_head;
   logic [FCNT_W-1:0] fifo_count;

   access_req_fifo #(
      .ID_W  (ID_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (fifo_push),
      .push_data (cmd_id),
      .pop       (fifo_pop),
      .head      (fifo_head),
      .full      (fifo_full),
      .empty     (fifo_empty),
      .count     (fifo_count)
   );

   assign cmd_ready  = !fifo_full && (state_q != LOCKOUT);
   assign fifo_push  = cmd_valid && cmd_ready;
   assign req_valid  = (state_q == ISSUE);
   assign rsp_valid  = (state_q == DONE);
   assign lockout    = (state_q == LOCKOUT);
   assign id_dynamic = id_dynamic_q;
   assign rsp_code   = rsp_code_q;
   assign rsp_tries  = tries_q;

   // id_dynamic is loaded on every entry to ISSUE so it is stable while req_valid is high.
   always_comb begin
      state_d      = state_q;
      tries_d      = tries_q;
      cnt_d        = cnt_q;
      id_dynamic_d = id_dynamic_q;
      rsp_code_d   = rsp_code_q;
      fifo_pop     = 1'b0;
      case (state_q)
         IDLE: begin
            if (!fifo_empty) begin
               state_d      = ISSUE;
               id_dynamic_d = fifo_head;
            end
         end
         ISSUE: begin
            tries_d = tries_q + 3'd1;
            cnt_d   = '0;
            state_d = WAIT;
         end
         WAIT: begin
            if (cnt_q == CNT_W'(RESP_LAT - 1)) begin
               if (access_granted) begin
                  state_d    = DONE;
                  rsp_code_d = RSP_GRANTED;
               end else if (access_denied && irq_flag) begin
                  state_d = LOCKOUT;
                  cnt_d   = '0;
               end else if (tries_q < 3'(MAX_TRIES)) begin
                  state_d      = ISSUE;
                  id_dynamic_d = fifo_head;
               end else begin
                  state_d    = DONE;
                  rsp_code_d = RSP_DENIED;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         LOCKOUT: begin
            if (cnt_q == CNT_W'(LOCKOUT_CYCLES - 1)) begin
               state_d    = DONE;
               rsp_code_d = RSP_LOCKED;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (rsp_ready) begin
               fifo_pop = (fifo_count != '0);
               tries_d  = 3'd0;
               state_d  = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         tries_q      <= 3'd0;
         cnt_q        <= '0;
         id_dynamic_q <= '0;
         rsp_code_q   <= 2'b00;
      end else begin
         state_q      <= state_d;
         tries_q      <= tries_d;
         cnt_q        <= cnt_d;
         id_dynamic_q <= id_dynamic_d;
         rsp_code_q   <= rsp_code_d;
      end
   end

`ifdef ACCESS_REQ_STATS_EN
   logic [15:0] grant_cnt_q, grant_cnt_d;
   logic [15:0] deny_cnt_q, deny_cnt_d;
   logic [7:0]  lock_cnt_q, lock_cnt_d;

   // A command completes on the result handshake, which is exactly when the FIFO pops.
   always_comb begin
      grant_cnt_d = grant_cnt_q;
      deny_cnt_d  = deny_cnt_q;
      lock_cnt_d  = lock_cnt_q;
      if (fifo_pop) begin
         case (rsp_code_q)
            RSP_GRANTED: if (grant_cnt_q != '1) grant_cnt_d = grant_cnt_q + 16'd1;
            RSP_DENIED:  if (deny_cnt_q != '1)  deny_cnt_d  = deny_cnt_q + 16'd1;
            RSP_LOCKED:  if (lock_cnt_q != '1)  lock_cnt_d  = lock_cnt_q + 8'd1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         grant_cnt_q <= '0;
         deny_cnt_q  <= '0;
         lock_cnt_q  <= '0;
      end else begin
         grant_cnt_q <= grant_cnt_d;
         deny_cnt_q  <= deny_cnt_d;
         lock_cnt_q  <= lock_cnt_d;
      end
   end

   assign grant_cnt = grant_cnt_q;
   assign deny_cnt  = deny_cnt_q;
   assign lock_cnt  = lock_cnt_q;
`endif

endmodule
